text_cursor_writer: RTL and testbench
=====================================

# text_cursor_writer

Converts PS/2 scan-code set-2 bytes into character writes for the text-mode frame RAM, maintaining a cursor (column, row) across the character grid. Sits between the PS/2 receiver and the text RAM write port. The scan-out side (font ROM, pixel printer) reads glyph indices from the RAM this block fills. Handles make/break/extended prefixes, shift state, enter, backspace, cursor arrows and a full-screen clear sweep.

## Interface
- COLS, 64, characters per row (power of two)
- ROWS, 16, rows per screen (power of two); COLS*ROWS ≤ 1024
- BLANK, 10'h020, glyph index written for space/erase

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- scan_code  in  8  received scan-code byte
- scan_valid  in  1  one-cycle strobe, scan_code valid
- clr  in  1  one-cycle strobe, start clear sweep
- wr_en  out  1  RAM write enable, one-cycle pulse
- wr_addr  out  10  RAM address = row*COLS + col
- wr_data  out  10  glyph index (ASCII zero-extended)
- cursor_col  out  log2(COLS)  current column
- cursor_row  out  log2(ROWS)  current row
- busy  out  1  high during clear sweep

## Operation
- States: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (E0 F0), CLEAR.
- IDLE + scan_valid: F0→BRK; E0→EXT; else process make code, stay IDLE.
- BRK + scan_valid: 0x12/0x59 clears shift; any other code ignored; →IDLE.
- EXT + scan_valid: F0→EXT_BRK; 0x6B cursor left, 0x74 cursor right (no write); else ignored; →IDLE.
- EXT_BRK + scan_valid: ignored; →IDLE.
- Make codes in IDLE:
  - 0x12/0x59: set shift.
  - Letters (set-2 A–Z, e.g. A=0x1C, Z=0x1A): write ASCII lowercase (0x61+), uppercase (0x41+) when shift set; advance cursor.
  - Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → ASCII '0'..'9', shift ignored; advance.
  - 0x29 space: write BLANK; advance.
  - 0x5A enter: col=0, row+1; no write.
  - 0x66 backspace: move cursor back one cell, write BLANK at new position. At (0,0): no move, write BLANK at 0.
  - All other codes ignored.
- Advance: col+1; at col=COLS-1 → col=0, row+1. Row increments wrap ROWS-1→0 (no scrolling).
- Left arrow: col-1; at col 0 → col=COLS-1, row-1 (row 0 wraps to ROWS-1). Right arrow equals advance without write.
- Write address uses the cursor position before the advance.
- clr (any state): →CLEAR, busy=1, counter 0. Each cycle writes BLANK at counter, counter+1; after address COLS*ROWS-1 →IDLE, busy=0, cursor (0,0), shift cleared.
- scan_valid while busy is dropped. clr during CLEAR restarts the sweep at 0.

## Timing
- Reset: wr_en=0, wr_addr=0, wr_data=0, cursor (0,0), shift=0, busy=0, state IDLE. No sweep on reset; RAM contents untouched.
- All outputs registered. scan_valid at cycle N → wr_en/wr_addr/wr_data valid at N+1; cursor updated at N+1.
- Accepts back-to-back scan_valid every cycle.
- clr and scan_valid in the same cycle: clr wins, byte dropped.
- Clear sweep: busy rises at N+1 after clr. The first write is at N+1. Exactly COLS*ROWS consecutive wr_en cycles. busy falls the cycle after the last write.
- rst mid-sweep aborts it immediately; the remaining cells are left unwritten.
- Prefix state persists indefinitely until the next scan_valid.

## Test plan
- Reset, send 1C, F0 1C → one write addr 0 data 0x061; cursor (1,0); no write for the break pair.
- Send 12, 1C, F0 12, 1C → writes 0x041 at addr 0 and 0x061 at addr 1; shift cleared after F0 12.
- Cursor at (63,0), send 29 → write 0x020 addr 63, cursor (0,1). At (63,15) → cursor (0,0).
- Cursor (0,1), send 66 → write 0x020 addr 63, cursor (63,0). At (0,0) → write addr 0, cursor stays.
- Send E0 6B from (0,0) → no write, cursor (63,15). E0 F0 6B → no action.
- Pulse clr with scan_valid the same cycle → 1024 writes of 0x020, addr 0..1023 in order. Bytes during busy are dropped. Cursor (0,0) at end. rst at write 500 → busy=0 next cycle.

Source files
------------

// File: rtl/text_cursor_writer_if.sv
// Keyboard-to-text-RAM bundle: scan-code input side, RAM write port, cursor and busy status.
interface text_cursor_writer_if #(
  parameter int COLS = 64,
  parameter int ROWS = 16
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    scan_code;
  logic          scan_valid;
  logic          clr;
  logic          wr_en;
  logic [9:0]    wr_addr;
  logic [9:0]    wr_data;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic          busy;

  modport master (
    output scan_code, scan_valid, clr,
    input  wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
  );

  modport slave (
    input  scan_code, scan_valid, clr,
    output wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_cursor_writer.sv
// PS/2 set-2 scan codes -> text RAM writes with a wrapping cursor; all outputs one cycle after input.
// Never stalls the keyboard side: bytes arriving during a clear sweep are dropped, clr always wins.
module text_cursor_writer #(
  parameter int          COLS  = 64,
  parameter int          ROWS  = 16,
  parameter logic [9:0]  BLANK = 10'h020
) (
  input  logic                 clk,
  input  logic                 rst,
  text_cursor_writer_if.slave  kb
);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int PW    = CW + RW;
  localparam int CNT_W = PW + 1;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_LSHFT = 8'h12;
  localparam logic [7:0] SC_RSHFT = 8'h59;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_CLEAR} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;     // {row, col}: carries out of col roll straight into row
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_q, shift_d;
  logic             wr_en_q, wr_en_d;
  logic [9:0]       wr_addr_q, wr_addr_d;
  logic [9:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    adv_pos, back_pos;
  logic [8:0]       lc, dg;
  logic             glyph_hit;
  logic [9:0]       glyph;

  function automatic logic [8:0] letter_lc(input logic [7:0] c);
    case (c)
      8'h1C: return 9'h161;  8'h32: return 9'h162;  8'h21: return 9'h163;  8'h23: return 9'h164;
      8'h24: return 9'h165;  8'h2B: return 9'h166;  8'h34: return 9'h167;  8'h33: return 9'h168;
      8'h43: return 9'h169;  8'h3B: return 9'h16A;  8'h42: return 9'h16B;  8'h4B: return 9'h16C;
      8'h3A: return 9'h16D;  8'h31: return 9'h16E;  8'h44: return 9'h16F;  8'h4D: return 9'h170;
      8'h15: return 9'h171;  8'h2D: return 9'h172;  8'h1B: return 9'h173;  8'h2C: return 9'h174;
      8'h3C: return 9'h175;  8'h2A: return 9'h176;  8'h1D: return 9'h177;  8'h22: return 9'h178;
      8'h35: return 9'h179;  8'h1A: return 9'h17A;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] digit_ascii(input logic [7:0] c);
    case (c)
      8'h45: return 9'h130;  8'h16: return 9'h131;  8'h1E: return 9'h132;  8'h26: return 9'h133;
      8'h25: return 9'h134;  8'h2E: return 9'h135;  8'h36: return 9'h136;  8'h3D: return 9'h137;
      8'h3E: return 9'h138;  8'h46: return 9'h139;
      default: return 9'h000;
    endcase
  endfunction

  assign adv_pos  = pos_q + PW'(1);
  assign back_pos = (pos_q == '0) ? pos_q : pos_q - PW'(1);
  assign lc       = letter_lc(kb.scan_code);
  assign dg       = digit_ascii(kb.scan_code);

  always_comb begin
    glyph_hit = 1'b0;
    glyph     = BLANK;
    if (lc[8]) begin
      glyph_hit = 1'b1;
      glyph     = {2'b00, shift_q ? (lc[7:0] - 8'h20) : lc[7:0]};
    end else if (dg[8]) begin
      glyph_hit = 1'b1;
      glyph     = {2'b00, dg[7:0]};
    end else if (kb.scan_code == SC_SPACE) begin
      glyph_hit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (kb.clr) begin
      state_d   = S_CLEAR;
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      wr_data_d = BLANK;
      cnt_d     = CNT_W'(1);
    end else begin
      case (state_q)
        S_IDLE: if (kb.scan_valid) begin
          if (kb.scan_code == SC_BRK) begin
            state_d = S_BRK;
          end else if (kb.scan_code == SC_EXT) begin
            state_d = S_EXT;
          end else if (kb.scan_code == SC_LSHFT || kb.scan_code == SC_RSHFT) begin
            shift_d = 1'b1;
          end else if (glyph_hit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 10'(pos_q);
            wr_data_d = glyph;
            pos_d     = adv_pos;
          end else if (kb.scan_code == SC_ENTER) begin
            pos_d = {pos_q[PW-1:CW] + RW'(1), {CW{1'b0}}};
          end else if (kb.scan_code == SC_BKSP) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 10'(back_pos);
            wr_data_d = BLANK;
            pos_d     = back_pos;
          end
        end
        S_BRK: if (kb.scan_valid) begin
          if (kb.scan_code == SC_LSHFT || kb.scan_code == SC_RSHFT) shift_d = 1'b0;
          state_d = S_IDLE;
        end
        S_EXT: if (kb.scan_valid) begin
          state_d = (kb.scan_code == SC_BRK) ? S_EXT_BRK : S_IDLE;
          if (kb.scan_code == SC_LEFT)  pos_d = pos_q - PW'(1);
          if (kb.scan_code == SC_RIGHT) pos_d = adv_pos;
        end
        S_EXT_BRK: if (kb.scan_valid) state_d = S_IDLE;
        S_CLEAR: begin
          // cnt runs one past the last cell so busy drops the cycle after the final write
          if (cnt_q[PW]) begin
            state_d = S_IDLE;
            pos_d   = '0;
            shift_d = 1'b0;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = 10'(cnt_q[PW-1:0]);
            wr_data_d = BLANK;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign kb.wr_en      = wr_en_q;
  assign kb.wr_addr    = wr_addr_q;
  assign kb.wr_data    = wr_data_q;
  assign kb.cursor_col = pos_q[CW-1:0];
  assign kb.cursor_row = pos_q[PW-1:CW];
  assign kb.busy       = busy_q;
endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: keyboard model with cursor arithmetic, write scoreboard and monitor.
module tb_text_cursor_writer;
  localparam int         COLS  = 64;
  localparam int         ROWS  = 16;
  localparam int         CELLS = COLS * ROWS;
  localparam int         CW    = $clog2(COLS);
  localparam int         RW    = $clog2(ROWS);
  localparam logic [9:0] BLANK = 10'h020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_cursor_writer_if #(.COLS(COLS), .ROWS(ROWS)) kb();
  text_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .kb(kb.slave)
  );

  typedef struct packed { logic [9:0] addr; logic [9:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t got_e;
  int  checks = 0, errors = 0, wcount = 0;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // reference keyboard/cursor state
  int m_col = 0, m_row = 0, busy_cycles = 0;
  bit m_shift = 0, m_f0 = 0, m_e0 = 0, rst_chk = 0;

  always @(negedge clk) begin
    if (kb.wr_en === 1'b1) begin
      wcount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0h data=%0h, expected no write", kb.wr_addr, kb.wr_data);
      end else begin
        got_e = exp_q.pop_front();
        if (kb.wr_addr !== got_e.addr || kb.wr_data !== got_e.data) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   kb.wr_addr, kb.wr_data, got_e.addr, got_e.data);
        end
      end
    end
  end

  task automatic push_write(input int col, input int row, input logic [9:0] d);
    wr_t w;
    w.addr = 10'(row * COLS + col);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic m_fwd();
    m_col++;
    if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
  endtask

  task automatic m_back();
    if (m_col == 0) begin m_col = COLS - 1; m_row = (m_row + ROWS - 1) % ROWS; end
    else m_col--;
  endtask

  task automatic m_make(input logic [7:0] c);
    int li = -1, di = -1;
    for (int i = 0; i < 26; i++) if (let_codes[i] == c) li = i;
    for (int i = 0; i < 10; i++) if (dig_codes[i] == c) di = i;
    if (c == 8'h12 || c == 8'h59) m_shift = 1;
    else if (li >= 0) begin push_write(m_col, m_row, 10'((m_shift ? 'h41 : 'h61) + li)); m_fwd(); end
    else if (di >= 0) begin push_write(m_col, m_row, 10'('h30 + di)); m_fwd(); end
    else if (c == 8'h29) begin push_write(m_col, m_row, BLANK); m_fwd(); end
    else if (c == 8'h5A) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
    else if (c == 8'h66) begin
      if (m_col != 0 || m_row != 0) m_back();
      push_write(m_col, m_row, BLANK);
    end
  endtask

  task automatic m_byte(input logic [7:0] c);
    if (m_e0 && m_f0) begin m_e0 = 0; m_f0 = 0; end
    else if (m_e0) begin
      if (c == 8'hF0) m_f0 = 1;
      else begin
        if (c == 8'h6B) m_back();
        if (c == 8'h74) m_fwd();
        m_e0 = 0;
      end
    end else if (m_f0) begin
      if (c == 8'h12 || c == 8'h59) m_shift = 0;
      m_f0 = 0;
    end else if (c == 8'hF0) m_f0 = 1;
    else if (c == 8'hE0) m_e0 = 1;
    else m_make(c);
  endtask

  // One cycle: check what the DUT shows now, then drive the next inputs and advance the model.
  task automatic step(input bit v, input logic [7:0] c, input bit cl, input bit r);
    bit exp_busy;
    @(negedge clk);
    #1;
    exp_busy = (busy_cycles > 0);
    checks++;
    if (kb.busy !== exp_busy) begin
      errors++;
      $display("FAIL busy got %b expected %b", kb.busy, exp_busy);
    end
    checks++;
    if (kb.cursor_col !== CW'(m_col) || kb.cursor_row !== RW'(m_row)) begin
      errors++;
      $display("FAIL cursor got (%0d,%0d) expected (%0d,%0d)", kb.cursor_col, kb.cursor_row, m_col, m_row);
    end
    if (rst_chk) begin
      rst_chk = 0;
      checks++;
      if (kb.wr_en !== 1'b0 || kb.wr_addr !== 10'h0 || kb.wr_data !== 10'h0) begin
        errors++;
        $display("FAIL reset_outputs got en=%b addr=%0h data=%0h expected all zero",
                 kb.wr_en, kb.wr_addr, kb.wr_data);
      end
    end
    if (busy_cycles > 0) begin
      busy_cycles--;
      if (busy_cycles == 0) begin m_col = 0; m_row = 0; m_shift = 0; end
    end
    rst           = r;
    kb.scan_valid = v;
    kb.scan_code  = c;
    kb.clr        = cl;
    if (r) begin
      exp_q.delete();
      m_col = 0; m_row = 0; m_shift = 0; m_e0 = 0; m_f0 = 0;
      busy_cycles = 0;
      rst_chk = 1;
    end else if (cl) begin
      exp_q.delete();
      for (int i = 0; i < CELLS; i++) push_write(i % COLS, i / COLS, BLANK);
      busy_cycles = CELLS;
      m_e0 = 0; m_f0 = 0;
    end else if (v && !exp_busy) begin
      m_byte(c);
    end
  endtask

  task automatic sendb(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((busy_cycles > 0 || exp_q.size() != 0) && n < limit) begin
      idle(1);
      n++;
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0 || busy_cycles != 0) begin
      errors++;
      $display("FAIL drain got %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [7:0] rand_code();
    int k = $urandom_range(0, 99);
    if (k < 30) return let_codes[$urandom_range(0, 25)];
    if (k < 40) return dig_codes[$urandom_range(0, 9)];
    if (k < 48) return 8'hF0;
    if (k < 54) return 8'hE0;
    if (k < 60) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
    if (k < 65) return 8'h29;
    if (k < 70) return 8'h5A;
    if (k < 76) return 8'h66;
    if (k < 84) return ($urandom_range(0, 1) != 0) ? 8'h6B : 8'h74;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int base;
    kb.scan_valid = 1'b0;
    kb.scan_code  = 8'h00;
    kb.clr        = 1'b0;
    do_reset();

    // plain letter, then its break pair
    sendb(8'h1C); sendb(8'hF0); sendb(8'h1C); idle(2);
    // shifted letter, release shift, lowercase again
    sendb(8'h12); sendb(8'h1C); sendb(8'hF0); sendb(8'h12); sendb(8'h1C); idle(2);

    // end-of-row wrap, then end-of-screen wrap
    do_reset();
    sendb(8'h5A); sendb(8'hE0); sendb(8'h6B); sendb(8'h29); idle(2);
    do_reset();
    sendb(8'hE0); sendb(8'h6B); sendb(8'h29); idle(2);

    // backspace across a row boundary and at the origin
    do_reset();
    sendb(8'h5A); sendb(8'h66); idle(2);
    do_reset();
    sendb(8'h66); idle(2);

    // extended left from origin, then an extended break is a no-op
    do_reset();
    sendb(8'hE0); sendb(8'h6B); sendb(8'hE0); sendb(8'hF0); sendb(8'h6B); idle(2);
    sendb(8'h45); sendb(8'h46); idle(2);

    // clear sweep with a simultaneous byte and keystrokes while busy
    base = wcount;
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) sendb(rand_code());
    drain(CELLS + 200);
    checks++;
    if (wcount - base != CELLS) begin
      errors++;
      $display("FAIL sweep_count got %0d writes expected %0d", wcount - base, CELLS);
    end
    sendb(8'h32); idle(2);

    // clr during a sweep restarts it
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(300);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    drain(CELLS + 200);

    // reset aborts a sweep after 500 writes
    sendb(8'h1C);
    idle(2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    base = wcount;
    idle(499);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (wcount - base != 500) begin
      errors++;
      $display("FAIL reset_abort got %0d writes expected 500", wcount - base);
    end

    // randomized keystrokes, back-to-back and gapped, with rare clears
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      else if ($urandom_range(0, 9) < 7) sendb(rand_code());
      else idle(1);
    end
    drain(CELLS + 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
